encoder8_3_seq: RTL and testbench

- Sequential 8-to-3 encoder. It is the inverse of the existing 3-to-8 decoder.
- Captures an 8-bit request vector and emits the 3-bit index of every set bit, one per handshake, lowest index first.
- Sits between request-vector sources (interrupt/request lines) and downstream logic that consumes binary codes, e.g. `decoder3_8` in loopback.

---
 rtl/enc_pkg.sv | 12 +
 rtl/prio_enc8.sv | 22 ++
 rtl/encoder8_3_seq.sv | 87 ++++++++
 tb/tb_encoder8_3_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential 8-to-3 encoder.
package enc_pkg;

    localparam int ENC_WIDTH  = 8;
    localparam int ENC_CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit encoder: bit 0 has highest priority.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [ENC_WIDTH-1:0]  vec,
    output logic [ENC_CODE_W-1:0] idx,
    output logic                  onehot,
    output logic                  any
);

    // Scan from the top down so the last hit wins, leaving the lowest index.
    // An empty vector encodes to 0.
    always_comb begin
        idx = '0;
        for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = ENC_CODE_W'(i);
        end
        any    = |vec;
        onehot = any && ((vec & (vec - ENC_WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/encoder8_3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index
// of every set bit, lowest first, one per out handshake.
// Optional build macro ENC_ZERO_ERR_EN adds an err port that pulses for one
// cycle after an all-zero vector is captured.
module encoder8_3_seq
    import enc_pkg::*;
#(
    parameter int WIDTH  = ENC_WIDTH,
    parameter int CODE_W = ENC_CODE_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ENC_ZERO_ERR_EN
    output logic              out_last,
    output logic              err
`else
    output logic              out_last
`endif
);

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic             started;   // low during reset, high from first edge after release
    logic             any_pend;

    // out/out_last come only from pend, never from the input ports.
    prio_enc8 u_prio (
        .vec    (pend),
        .idx    (out),
        .onehot (out_last),
        .any    (any_pend)
    );

    assign in_ready = started && (state == IDLE);

    // Capture in IDLE, retire the lowest pending bit per handshake in SCAN.
    // pend & (pend - 1) clears exactly the lowest set bit, i.e. the one on out.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            pend      <= '0;
            out_valid <= 1'b0;
            started   <= 1'b0;
`ifdef ENC_ZERO_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            started <= 1'b1;
`ifdef ENC_ZERO_ERR_EN
            err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pend <= in;
                        if (in != '0) begin
                            state     <= SCAN;
                            out_valid <= 1'b1;
                        end
`ifdef ENC_ZERO_ERR_EN
                        else begin
                            err <= 1'b1;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (out_ready && any_pend) begin
                        pend <= pend & (pend - WIDTH'(1));
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder8_3_seq.sv
// Self-checking bench for encoder8_3_seq: a queue of expected codes models
// the block; each captured vector expands into its set-bit indices in order.
module tb_encoder8_3_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] in_vec  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
`ifdef ENC_ZERO_ERR_EN
    logic       err;
`endif

    encoder8_3_seq dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in        (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ENC_ZERO_ERR_EN
        .out_last  (out_last),
        .err       (err)
`else
        .out_last  (out_last)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         q[$];          // expected codes still to be emitted
    bit         started = 1'b0;
    bit         err_exp = 1'b0;
    logic [7:0] acc;           // OR of decoded one-hot of every accepted code

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string ctx);
        chk({ctx, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({ctx, ".out"},       32'(out),       (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({ctx, ".out_last"},  32'(out_last),  32'(q.size() == 1));
        chk({ctx, ".in_ready"},  32'(in_ready),  32'(started && q.size() == 0 && !sys_rst));
`ifdef ENC_ZERO_ERR_EN
        chk({ctx, ".err"},       32'(err),       32'(err_exp));
`endif
    endtask

    // One clock: decide handshakes from the model, advance it at the edge,
    // then compare DUT outputs 1 time unit later.
    task automatic cyc(input string ctx);
        bit cap, pop;
        int tmp;
        cap = in_valid && started && q.size() == 0 && !sys_rst;
        pop = q.size() > 0 && out_ready && !sys_rst;
        if (pop && out_valid) acc |= 8'(1) << out;
        @(posedge sys_clk);
        if (pop) tmp = q.pop_front();
        err_exp = 1'b0;
        if (cap) begin
            if (in_vec == 8'h00) err_exp = 1'b1;
            for (int i = 0; i < 8; i++) if (in_vec[i]) q.push_back(i);
        end
        started = !sys_rst;
        #1 check_outs(ctx);
    endtask

    task automatic send(input logic [7:0] v, input string ctx);
        in_vec   = v;
        in_valid = 1'b1;
        cyc(ctx);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string ctx);
        int n = 0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 20) begin
            cyc(ctx);
            n++;
        end
        chk({ctx, ".drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset(input string ctx);
        sys_rst = 1'b1;
        q.delete();
        started = 1'b0;
        err_exp = 1'b0;
        #1 check_outs({ctx, ".async"});
        repeat (3) cyc({ctx, ".hold"});
        sys_rst = 1'b0;
        #1 check_outs({ctx, ".released"});
        cyc({ctx, ".first_edge"});
    endtask

    initial begin
        logic [7:0] v;
        int n;

        // Reset and release
        #1 check_outs("reset0");
        do_reset("reset");

        // Single bit
        out_ready = 1'b1;
        send(8'h10, "single");
        cyc("single.after");
        cyc("single.idle");

        // Multi-bit ordering with in_valid pulsed during SCAN
        send(8'hA5, "multi");
        in_vec = 8'hFF; in_valid = 1'b1;
        cyc("multi.ign0");
        cyc("multi.ign1");
        in_valid = 1'b0;
        drain("multi");
        cyc("multi.idle");

        // Back-pressure
        out_ready = 1'b0;
        send(8'h06, "bp");
        repeat (4) cyc("bp.hold");
        drain("bp");
        cyc("bp.idle");

        // Boundaries
        send(8'h80, "top");
        drain("top");
        cyc("top.idle");
        send(8'hFF, "full");
        drain("full");
        cyc("full.idle");

        // Reset mid-operation
        send(8'hFF, "midrst");
        repeat (3) cyc("midrst.codes");
        #2;
        do_reset("midrst");
        send(8'h01, "after_rst");
        drain("after_rst");
        cyc("after_rst.idle");

        // Zero vector
        send(8'h00, "zero");
        cyc("zero.after");
        cyc("zero.idle");

        // Randomized loopback: decoding each accepted code and OR-ing must
        // reproduce the captured vector.
        for (int k = 0; k < 64; k++) begin
            v   = 8'($urandom);
            acc = '0;
            out_ready = 1'($urandom_range(0, 1));
            send(v, "rand");
            n = 0;
            while (q.size() > 0 && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = (q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_vec    = 8'($urandom);
                cyc("rand.scan");
                n++;
            end
            in_valid = 1'b0;
            chk("rand.drained", 32'(q.size()), 32'd0);
            chk("rand.loopback", 32'(acc), 32'(v));
            if ($urandom_range(0, 1) == 1) cyc("rand.gap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
